// File: rtl/i2c_pkg.sv
// i2c_pkg: state encoding, widths and address helper shared by the
// I2C target receiver (i2c_slave_rx) and its line conditioner.
package i2c_pkg;

    localparam int   I2C_ADDR_W  = 7;
    localparam int   I2C_BYTE_W  = 8;
    localparam logic I2C_RW_READ = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        IGNORE
    } i2c_rx_state_t;

    // Conditioned view of one bus line: current level plus edge pulses.
    typedef struct packed {
        logic level;
        logic rise;
        logic fall;
    } line_ev_t;

    // True when an address byte selects this target for a write.
    function automatic logic addr_hit(
        input logic [I2C_BYTE_W-1:0] addr_byte,
        input logic [I2C_ADDR_W-1:0] own_addr
    );
        return (addr_byte[I2C_BYTE_W-1:1] == own_addr) &&
               (addr_byte[0] != I2C_RW_READ);
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: synchronizer, optional 3-sample agreement filter
// (I2C_GLITCH_FILTER_EN) and rise/fall pulse generation for one line.
module i2c_line_sync
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     raw,
    output line_ev_t ev
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;

    // Idle bus level is high, so reset to 1 to avoid a spurious edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

`ifdef I2C_GLITCH_FILTER_EN
    logic [1:0] hist_q;
    logic       filt_q;
    logic       agree;
    logic       level;

    // The current sample and the two before it must all agree.
    assign agree = (synced == hist_q[0]) && (synced == hist_q[1]);
    assign level = agree ? synced : filt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q <= '1;
            filt_q <= 1'b1;
        end else begin
            hist_q <= {hist_q[0], synced};
            filt_q <= level;
        end
    end

    assign ev.level = level;
    assign ev.rise  = level & ~filt_q;
    assign ev.fall  = ~level & filt_q;
`else
    logic prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= synced;
        end
    end

    assign ev.level = synced;
    assign ev.rise  = synced & ~prev_q;
    assign ev.fall  = ~synced & prev_q;
`endif

endmodule

// File: rtl/i2c_slave_rx.sv
// i2c_slave_rx: write-only I2C target; ACKs its address and each data
// byte and strobes received bytes out. Filter option: I2C_GLITCH_FILTER_EN.
module i2c_slave_rx
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h55,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  scl_in,
    input  logic                  sda_in,
    output logic                  sda_oe,
    output logic [I2C_BYTE_W-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  addr_match,
    output logic                  bus_busy
);

    line_ev_t scl;
    line_ev_t sda;

    i2c_line_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_scl_sync (
        .clk  (clk),
        .reset(reset),
        .raw  (scl_in),
        .ev   (scl)
    );

    i2c_line_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sda_sync (
        .clk  (clk),
        .reset(reset),
        .raw  (sda_in),
        .ev   (sda)
    );

    i2c_rx_state_t           state;
    logic [2:0]              bit_cnt;
    logic [I2C_BYTE_W-2:0]   shift;
    logic                    oe_q;
    logic                    start;
    logic                    stop;
    logic                    last_bit;
    logic [I2C_BYTE_W-1:0]   next_byte;

    assign start     = scl.level & sda.fall;
    assign stop      = scl.level & sda.rise;
    assign last_bit  = (bit_cnt == 3'd7);
    assign next_byte = {shift, sda.level};

    // Gating with reset lets SDA go free in the cycle reset is raised.
    assign sda_oe = oe_q & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= 3'd0;
            shift      <= '0;
            oe_q       <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            addr_match <= 1'b0;
            bus_busy   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (stop) begin
                state      <= IDLE;
                bit_cnt    <= 3'd0;
                oe_q       <= 1'b0;
                addr_match <= 1'b0;
                bus_busy   <= 1'b0;
            end else if (start) begin
                state      <= ADDR;
                bit_cnt    <= 3'd0;
                shift      <= '0;
                oe_q       <= 1'b0;
                addr_match <= 1'b0;
                bus_busy   <= 1'b1;
            end else begin
                unique case (state)
                    IDLE, IGNORE: begin
                        oe_q <= 1'b0;
                    end
                    ADDR: begin
                        if (scl.rise) begin
                            shift <= next_byte[I2C_BYTE_W-2:0];
                            if (last_bit) begin
                                state <= addr_hit(next_byte, SLAVE_ADDR) ?
                                         ADDR_ACK : IGNORE;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end
                    DATA: begin
                        if (scl.rise) begin
                            shift <= next_byte[I2C_BYTE_W-2:0];
                            if (last_bit) begin
                                rx_data  <= next_byte;
                                rx_valid <= 1'b1;
                                state    <= DATA_ACK;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end
                    // First fall drives the ACK, the second one ends it.
                    ADDR_ACK, DATA_ACK: begin
                        if (scl.fall) begin
                            if (!oe_q) begin
                                oe_q       <= 1'b1;
                                addr_match <= 1'b1;
                            end else begin
                                oe_q    <= 1'b0;
                                bit_cnt <= 3'd0;
                                state   <= DATA;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_rx.sv
// tb_i2c_slave_rx: directed vector table, hand-written corner sequences
// and randomized transfers checked against a transaction-level model.
module tb_i2c_slave_rx;

    localparam int         Q    = 10;
    localparam logic [6:0] ADDR = 7'h55;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       scl_drv = 1'b1;
    logic       sda_drv = 1'b1;
    logic       sda_bus;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       addr_match;
    logic       bus_busy;

    assign sda_bus = sda_drv & ~sda_oe;

    i2c_slave_rx #(
        .SLAVE_ADDR (ADDR),
        .SYNC_STAGES(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .scl_in    (scl_drv),
        .sda_in    (sda_bus),
        .sda_oe    (sda_oe),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .addr_match(addr_match),
        .bus_busy  (bus_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]       a;
        int               n;
        logic [3:0][7:0]  d;
        int               cut;
        bit               e_ack;
        int               e_n;
        logic [7:0]       e_last;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] rx_q[$];
    int         oe_cnt  = 0;
    int         rv_long = 0;
    bit         rv_prev = 1'b0;
    logic [7:0] exp_rx_data = 8'h00;

    always @(negedge clk) begin
        if (rx_valid === 1'b1) rx_q.push_back(rx_data);
        if (sda_oe === 1'b1) oe_cnt++;
        if (rx_valid === 1'b1 && rv_prev) rv_long++;
        rv_prev = (rx_valid === 1'b1);
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_cond();
        sda_drv = 1'b1;
        wait_clk(Q);
        scl_drv = 1'b1;
        wait_clk(Q);
        sda_drv = 1'b0;
        wait_clk(Q);
        scl_drv = 1'b0;
        wait_clk(Q);
    endtask

    task automatic stop_cond();
        sda_drv = 1'b0;
        wait_clk(Q);
        scl_drv = 1'b1;
        wait_clk(Q);
        sda_drv = 1'b1;
        wait_clk(Q);
    endtask

    task automatic send_bit(input logic b);
        sda_drv = b;
        wait_clk(Q);
        scl_drv = 1'b1;
        wait_clk(2 * Q);
        scl_drv = 1'b0;
        wait_clk(Q);
    endtask

    task automatic send_bits(input logic [7:0] b, input int nb);
        for (int i = 7; i > 7 - nb; i--) send_bit(b[i]);
    endtask

    // Returns SDA sampled early and late in the 9th high phase.
    task automatic ack_bit(output logic [1:0] s);
        sda_drv = 1'b1;
        wait_clk(Q);
        scl_drv = 1'b1;
        wait_clk(1);
        s[1] = sda_bus;
        wait_clk(2 * Q - 2);
        s[0] = sda_bus;
        wait_clk(1);
        scl_drv = 1'b0;
        wait_clk(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic [1:0] s);
        send_bits(b, 8);
        ack_bit(s);
    endtask

    // Transaction model: only a write to our own address is acknowledged.
    function automatic bit model_ack(input logic [7:0] a);
        return a == {ADDR, 1'b0};
    endfunction

    task automatic run_txn(input vec_t v, input string tag);
        logic [1:0] s;
        int         rx_base;
        int         oe_base;
        int         rvl_base;
        rx_base  = rx_q.size();
        oe_base  = oe_cnt;
        rvl_base = rv_long;
        start_cond();
        chk({tag, " busy after start"}, 32'(bus_busy), 32'd1);
        send_byte(v.a, s);
        chk({tag, " addr ack"}, 32'(s), v.e_ack ? 32'd0 : 32'd3);
        chk({tag, " addr_match"}, 32'(addr_match), 32'(v.e_ack));
        for (int i = 0; i < v.n; i++) begin
            send_byte(v.d[i], s);
            chk({tag, " data ack"}, 32'(s), v.e_ack ? 32'd0 : 32'd3);
        end
        if (v.cut > 0) send_bits(8'hA5, v.cut);
        stop_cond();
        wait_clk(8);
        chk({tag, " busy after stop"}, 32'(bus_busy), 32'd0);
        chk({tag, " match after stop"}, 32'(addr_match), 32'd0);
        chk({tag, " rx count"}, 32'(rx_q.size() - rx_base), 32'(v.e_n));
        if (v.e_ack) begin
            for (int i = 0; i < v.n && rx_base + i < rx_q.size(); i++)
                chk({tag, " rx byte"}, 32'(rx_q[rx_base + i]), 32'(v.d[i]));
        end
        chk({tag, " rx_data held"}, 32'(rx_data), 32'(v.e_last));
        chk({tag, " rx_valid width"}, 32'(rv_long - rvl_base), 32'd0);
        if (!v.e_ack) chk({tag, " sda never pulled"}, 32'(oe_cnt - oe_base), 32'd0);
        exp_rx_data = v.e_last;
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs[5];
        vec_t       rv;
        logic [1:0] s;
        int         base;

        vecs[0] = '{8'hAA, 1, 32'h0000003C, 0, 1'b1, 1, 8'h3C};
        vecs[1] = '{8'hA8, 1, 32'h000000FF, 0, 1'b0, 0, 8'h3C};
        vecs[2] = '{8'hAB, 1, 32'h00000012, 0, 1'b0, 0, 8'h3C};
        vecs[3] = '{8'hAA, 1, 32'h00000077, 5, 1'b1, 1, 8'h77};
        vecs[4] = '{8'hAA, 3, 32'h00C35A01, 0, 1'b1, 3, 8'hC3};

        wait_clk(4);
        chk("reset sda_oe", 32'(sda_oe), 32'd0);
        chk("reset rx_valid", 32'(rx_valid), 32'd0);
        chk("reset bus_busy", 32'(bus_busy), 32'd0);
        chk("reset addr_match", 32'(addr_match), 32'd0);
        chk("reset rx_data", 32'(rx_data), 32'd0);
        reset = 1'b0;
        wait_clk(4);

        for (int i = 0; i < 5; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Repeated start inside a write.
        base = rx_q.size();
        start_cond();
        send_byte(8'hAA, s);
        chk("rs addr ack", 32'(s), 32'd0);
        send_byte(8'h01, s);
        send_byte(8'h02, s);
        chk("rs match before", 32'(addr_match), 32'd1);
        start_cond();
        chk("rs match dropped", 32'(addr_match), 32'd0);
        chk("rs busy", 32'(bus_busy), 32'd1);
        send_byte(8'hAA, s);
        chk("rs readdr ack", 32'(s), 32'd0);
        chk("rs match again", 32'(addr_match), 32'd1);
        send_byte(8'h03, s);
        stop_cond();
        wait_clk(8);
        chk("rs rx count", 32'(rx_q.size() - base), 32'd3);
        for (int i = 0; i < 3 && base + i < rx_q.size(); i++)
            chk("rs rx byte", 32'(rx_q[base + i]), 32'(i + 1));
        exp_rx_data = 8'h03;

        // Reset while the address ACK is being driven.
        start_cond();
        send_bits(8'hAA, 8);
        sda_drv = 1'b1;
        wait_clk(Q);
        scl_drv = 1'b1;
        wait_clk(Q);
        chk("rst ack active", 32'(sda_oe), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst sda released", 32'(sda_oe), 32'd0);
        wait_clk(2);
        chk("rst busy", 32'(bus_busy), 32'd0);
        chk("rst match", 32'(addr_match), 32'd0);
        chk("rst rx_valid", 32'(rx_valid), 32'd0);
        chk("rst rx_data", 32'(rx_data), 32'd0);
        reset = 1'b0;
        scl_drv = 1'b0;
        wait_clk(Q);
        rv = '{8'hAA, 1, 32'h0000005A, 0, 1'b1, 1, 8'h5A};
        run_txn(rv, "post-reset");

`ifdef I2C_GLITCH_FILTER_EN
        // A 2-clk SCL spike in a low phase must not add a bit.
        base = rx_q.size();
        start_cond();
        send_byte(8'hAA, s);
        for (int i = 7; i >= 0; i--) begin
            sda_drv = (8'h96 >> i) & 8'h01;
            wait_clk(4);
            if (i == 4) begin
                scl_drv = 1'b1;
                wait_clk(2);
                scl_drv = 1'b0;
                wait_clk(Q - 6);
            end else begin
                wait_clk(Q - 4);
            end
            scl_drv = 1'b1;
            wait_clk(2 * Q);
            scl_drv = 1'b0;
            wait_clk(Q);
        end
        ack_bit(s);
        chk("glitch data ack", 32'(s), 32'd0);
        stop_cond();
        wait_clk(8);
        chk("glitch rx count", 32'(rx_q.size() - base), 32'd1);
        chk("glitch rx_data", 32'(rx_data), 32'h96);
        exp_rx_data = 8'h96;
`endif

        for (int t = 0; t < 14; t++) begin
            rv.a   = ($urandom_range(0, 1) == 1) ? 8'hAA : 8'($urandom);
            rv.n   = $urandom_range(0, 3);
            rv.d   = $urandom;
            rv.cut = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            rv.e_ack  = model_ack(rv.a);
            rv.e_n    = rv.e_ack ? rv.n : 0;
            rv.e_last = (rv.e_ack && rv.n > 0) ? rv.d[rv.n - 1] : exp_rx_data;
            run_txn(rv, $sformatf("rand%0d", t));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
